// File: rtl/key_speed_pkg.sv
// Shared types and constants for the key-driven breathing-speed controller.
package key_speed_pkg;

  localparam int SPEED_W          = 2;
  localparam int CNT_DEB_MAX_DEF  = 1_000_000;
  localparam int LONG_WIN_MAX_DEF = 50;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key line; resets to the released level (1).
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic meta;

  // Two register stages to settle metastability before the FSM sees the key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/key_speed_ctrl.sv
// Debounced key controller: short presses step the breathing speed, long
// presses toggle pause. Long-press path is built only when KEY_LONG_PRESS_EN
// is defined; otherwise every debounced press/release counts as short.
module key_speed_ctrl
  import key_speed_pkg::*;
#(
  parameter int CNT_DEB_MAX  = CNT_DEB_MAX_DEF,
  parameter int LONG_WIN_MAX = LONG_WIN_MAX_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               key_in,
  output logic [SPEED_W-1:0] speed_sel,
  output logic               pause,
  output logic               key_flag,
  output logic               long_flag
);

  localparam int DEB_W = (CNT_DEB_MAX > 1) ? $clog2(CNT_DEB_MAX) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(CNT_DEB_MAX - 1);

  // Reject parameter sets for which the counters would be meaningless.
  if (CNT_DEB_MAX < 2 || LONG_WIN_MAX < 1) begin : g_bad_params
    $error("key_speed_ctrl: CNT_DEB_MAX must be >= 2 and LONG_WIN_MAX >= 1");
  end

  key_state_t       state;
  logic [DEB_W-1:0] cnt_deb;
  logic             key_s;

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_WIN_MAX + 1);
  localparam logic [LONG_W-1:0] LONG_TOP  = LONG_W'(LONG_WIN_MAX);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_WIN_MAX - 1);

  logic [LONG_W-1:0] cnt_long;
  logic              long_done;
`else
  assign pause     = 1'b0;
  assign long_flag = 1'b0;
`endif

  key_sync u_key_sync (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .din  (key_in),
    .dout (key_s)
  );

  // Press/release debounce FSM with registered speed, pause and pulse outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt_deb   <= '0;
      speed_sel <= '0;
      key_flag  <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      cnt_long  <= '0;
      long_done <= 1'b0;
      pause     <= 1'b0;
      long_flag <= 1'b0;
`endif
    end else begin
      key_flag  <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_flag <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (!key_s) begin
            state   <= DEB_PRESS;
            cnt_deb <= '0;
          end
        end
        DEB_PRESS: begin
          if (key_s) begin
            state   <= IDLE;
            cnt_deb <= '0;
          end else if (cnt_deb == DEB_LAST) begin
            state    <= HELD;
            cnt_deb  <= '0;
`ifdef KEY_LONG_PRESS_EN
            cnt_long <= '0;
`endif
          end else begin
            cnt_deb <= cnt_deb + 1'b1;
          end
        end
        HELD: begin
          if (key_s) begin
            state   <= DEB_RELEASE;
            cnt_deb <= '0;
          end
`ifdef KEY_LONG_PRESS_EN
          else if (cnt_deb == DEB_LAST) begin
            cnt_deb <= '0;
            if (cnt_long != LONG_TOP) begin
              cnt_long <= cnt_long + 1'b1;
            end
            if (cnt_long == LONG_LAST) begin
              long_flag <= 1'b1;
              pause     <= ~pause;
              long_done <= 1'b1;
            end
          end else begin
            cnt_deb <= cnt_deb + 1'b1;
          end
`endif
        end
        DEB_RELEASE: begin
          if (!key_s) begin
            state   <= HELD;
            cnt_deb <= '0;
          end else if (cnt_deb == DEB_LAST) begin
            state   <= IDLE;
            cnt_deb <= '0;
`ifdef KEY_LONG_PRESS_EN
            if (!long_done) begin
              key_flag  <= 1'b1;
              speed_sel <= speed_sel + 1'b1;
            end
            long_done <= 1'b0;
`else
            key_flag  <= 1'b1;
            speed_sel <= speed_sel + 1'b1;
`endif
          end else begin
            cnt_deb <= cnt_deb + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt_deb <= '0;
        end
      endcase
    end
  end

endmodule
